// File: rtl/lcd_bus_transceiver.sv
// HD44780-style parallel LCD bus master: turns one request into a timed RS/RW/E cycle
// (or two half-width cycles in nibble mode) and returns read data with a one-cycle response.
module lcd_bus_transceiver #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NIBBLE_MODE = 0,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic              req_rs,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              bus_rs,
  output logic              bus_rw,
  output logic              bus_e,
  inout  wire  [DATA_W-1:0] bus_io
);

  localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MaxCyc = (MaxSp > HOLD_CYC) ? MaxSp : HOLD_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  // Nibble mode requires an even DATA_W; odd widths are not a legal configuration.
  localparam int unsigned HalfW  = DATA_W / 2;

  localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ph_q, ph_d;
  logic              rw_q, rs_q;
  logic [DATA_W-1:0] data_q, rd_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              hs, done, sample_rd, drive_en;

  assign hs = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    done      = 1'b0;
    sample_rd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          state_d = StSetup;
          cnt_d   = '0;
          ph_d    = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StPulse;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          // Read data is captured on the edge that ends the pulse, while E is still high.
          sample_rd = 1'b1;
          state_d   = StHold;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          if ((NIBBLE_MODE != 0) && !ph_q) begin
            state_d = StSetup;
            ph_d    = 1'b1;
          end else begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    busy      = (state_q != StIdle);
    bus_e     = (state_q == StPulse);
    bus_rs    = busy ? rs_q : 1'b0;
    bus_rw    = busy ? rw_q : 1'b0;
    drive_en  = busy && !rw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= done;
      if (hs) begin
        rw_q   <= req_rw;
        rs_q   <= req_rs;
        data_q <= req_data;
      end
      if (sample_rd && rw_q) begin
        if (NIBBLE_MODE != 0) begin
          if (ph_q) rd_q[HalfW-1:0] <= bus_io[DATA_W-1:HalfW];
          else      rd_q[DATA_W-1:HalfW] <= bus_io[DATA_W-1:HalfW];
        end else begin
          rd_q <= bus_io;
        end
      end
      if (done) rsp_data_q <= rw_q ? rd_q : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  if (NIBBLE_MODE != 0) begin : g_nibble
    // Upper half carries the high nibble in phase 0 and the low nibble in phase 1.
    assign bus_io[DATA_W-1:HalfW] = drive_en ? (ph_q ? data_q[HalfW-1:0]
                                                     : data_q[DATA_W-1:HalfW]) : 'z;
    assign bus_io[HalfW-1:0]      = 'z;
  end else begin : g_full
    assign bus_io = drive_en ? data_q : 'z;
  end

endmodule

// File: tb/tb_lcd_bus_transceiver.sv
// Bench for lcd_bus_transceiver: full-width and nibble-mode instances driven by directed and
// random transactions, compared cycle by cycle against a timing model built from phase windows.
module tb_lcd_bus_transceiver;
  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int N = S + P + H;

  typedef struct packed {
    logic       ready;
    logic       rv;
    logic       busy;
    logic       rs;
    logic       rw;
    logic       e;
    logic [7:0] rdata;
    logic [7:0] bus;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid0, req_valid1, req_rw, req_rs;
  logic [7:0] req_data;
  logic       ready0, ready1, rv0, rv1, busy0, busy1, brs0, brs1, brw0, brw1, e0, e1;
  logic [7:0] rdata0, rdata1;
  wire  [7:0] bus0, bus1;
  logic       probe;
  logic [7:0] pval, mval, last0, last1;
  logic [3:0] lo_pat;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // Peripheral model: drives read data while E is high and its complement otherwise, so a
  // capture at the wrong moment shows up. The bench also probes the bus while it should float.
  assign bus0      = brw0 ? (e0 ? mval : ~mval) : (probe ? pval : 8'hzz);
  assign bus1[7:4] = brw1 ? (e1 ? mval[7:4] : ~mval[7:4]) : (probe ? pval[7:4] : 4'hz);
  assign bus1[3:0] = lo_pat;

  lcd_bus_transceiver u_full (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(ready0), .req_rw(req_rw),
    .req_rs(req_rs), .req_data(req_data), .rsp_valid(rv0), .rsp_data(rdata0), .busy(busy0),
    .bus_rs(brs0), .bus_rw(brw0), .bus_e(e0), .bus_io(bus0)
  );

  lcd_bus_transceiver #(.NIBBLE_MODE(1)) u_nib (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(ready1), .req_rw(req_rw),
    .req_rs(req_rs), .req_data(req_data), .rsp_valid(rv1), .rsp_data(rdata1), .busy(busy1),
    .bus_rs(brs1), .bus_rw(brw1), .bus_e(e1), .bus_io(bus1)
  );

  function automatic snap_t snap(input bit nib);
    snap_t s;
    if (nib) s = {ready1, rv1, busy1, brs1, brw1, e1, rdata1, bus1};
    else     s = {ready0, rv0, busy0, brs0, brw0, e0, rdata0, bus0};
    return s;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with the selected instance idle.
  task automatic do_txn(input bit nib, input bit rw, input bit rs, input logic [7:0] data,
                        input logic [7:0] rdv, input bit hold);
    int         len;
    int         p;
    int         w;
    bit         pe;
    logic [3:0] cur;
    logic [7:0] exp_bus;
    logic [7:0] exp_rsp;
    snap_t      s;
    len      = nib ? 2 * N : N;
    probe    = 1'b0;
    req_rw   = rw;
    req_rs   = rs;
    req_data = data;
    if (nib) req_valid1 = 1'b1;
    else     req_valid0 = 1'b1;
    #1;
    s = snap(nib);
    chk1("req_ready_idle", s.ready, 1'b1);
    @(posedge clk);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      if (!hold) begin
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
      end
      req_rw   = 1'($urandom);
      req_rs   = 1'($urandom);
      req_data = 8'($urandom);
      p    = t / N;
      w    = t % N;
      pe   = (w >= S) && (w < S + P);
      cur  = (p == 0) ? rdv[7:4] : rdv[3:0];
      mval = nib ? {cur, 4'h0} : rdv;
      #1;
      s = snap(nib);
      chk1("bus_e", s.e, pe);
      chk1("busy", s.busy, 1'b1);
      chk1("req_ready_busy", s.ready, 1'b0);
      chk1("rsp_valid_early", s.rv, 1'b0);
      chk1("bus_rs", s.rs, rs);
      chk1("bus_rw", s.rw, rw);
      if (rw) exp_bus = nib ? {(pe ? cur : ~cur), lo_pat} : (pe ? rdv : ~rdv);
      else    exp_bus = nib ? {((p == 0) ? data[7:4] : data[3:0]), lo_pat} : data;
      chk8("bus_io", s.bus, exp_bus);
    end
    @(negedge clk);
    #1;
    s       = snap(nib);
    exp_rsp = rw ? rdv : 8'h00;
    chk1("rsp_valid", s.rv, 1'b1);
    chk8("rsp_data", s.rdata, exp_rsp);
    chk1("busy_done", s.busy, 1'b0);
    chk1("bus_e_done", s.e, 1'b0);
    chk1("bus_rs_idle", s.rs, 1'b0);
    chk1("bus_rw_idle", s.rw, 1'b0);
    chk1("req_ready_rsp", s.ready, 1'b1);
    if (nib) last1 = exp_rsp;
    else     last0 = exp_rsp;
  endtask

  task automatic idle(input int n);
    snap_t s0;
    snap_t s1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      probe = 1'b1;
      pval  = 8'($urandom);
      #1;
      s0 = snap(1'b0);
      s1 = snap(1'b1);
      chk8("bus_io_idle_z", s0.bus, pval);
      chk8("bus_io_idle_z_nib", s1.bus, {pval[7:4], lo_pat});
      chk1("rsp_valid_idle", s0.rv, 1'b0);
      chk1("rsp_valid_idle_nib", s1.rv, 1'b0);
      chk1("busy_idle", s0.busy, 1'b0);
      chk1("busy_idle_nib", s1.busy, 1'b0);
      chk8("rsp_data_hold", s0.rdata, last0);
      chk8("rsp_data_hold_nib", s1.rdata, last1);
    end
  endtask

  task automatic mid_reset();
    snap_t s;
    probe      = 1'b0;
    req_rw     = 1'b0;
    req_rs     = 1'b1;
    req_data   = 8'($urandom);
    req_valid0 = 1'b1;
    #1;
    @(posedge clk);
    for (int t = 0; t <= S + 1; t++) begin
      @(negedge clk);
      req_valid0 = 1'b0;
    end
    #1;
    s = snap(1'b0);
    chk1("bus_e_before_reset", s.e, 1'b1);
    rst        = 1'b1;
    req_valid0 = 1'b1;
    #1;
    s = snap(1'b0);
    chk1("req_ready_in_reset", s.ready, 1'b0);
    @(negedge clk);
    rst        = 1'b0;
    req_valid0 = 1'b0;
    probe      = 1'b1;
    pval       = 8'($urandom);
    #1;
    s = snap(1'b0);
    chk1("bus_e_after_reset", s.e, 1'b0);
    chk1("busy_after_reset", s.busy, 1'b0);
    chk1("req_ready_after_reset", s.ready, 1'b1);
    chk1("rsp_valid_after_reset", s.rv, 1'b0);
    chk8("rsp_data_after_reset", s.rdata, 8'h00);
    chk8("bus_io_after_reset", s.bus, pval);
    last0 = 8'h00;
    last1 = 8'h00;
    idle(N + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit    nb;
    bit    hd;
    snap_t s;
    rst        = 1'b1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_rw     = 1'b0;
    req_rs     = 1'b0;
    req_data   = 8'h00;
    probe      = 1'b1;
    pval       = 8'($urandom);
    mval       = 8'h00;
    lo_pat     = 4'($urandom);
    last0      = 8'h00;
    last1      = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      s = snap(i == 1);
      chk1("reset_bus_e", s.e, 1'b0);
      chk1("reset_bus_rs", s.rs, 1'b0);
      chk1("reset_bus_rw", s.rw, 1'b0);
      chk1("reset_busy", s.busy, 1'b0);
      chk1("reset_rsp_valid", s.rv, 1'b0);
      chk8("reset_rsp_data", s.rdata, 8'h00);
      chk1("reset_req_ready", s.ready, 1'b0);
    end
    chk8("reset_bus_io_z", bus0, pval);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("ready_after_reset_full", ready0, 1'b1);
    chk1("ready_after_reset_nib", ready1, 1'b1);
    idle(2);

    do_txn(1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0);
    idle(2);
    do_txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0);
    idle(1);
    do_txn(1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0);
    idle(1);
    do_txn(1'b1, 1'b1, 1'b1, 8'h00, 8'h96, 1'b0);
    idle(1);

    // Back-to-back with req_valid held high.
    do_txn(1'b0, 1'b0, 1'b1, 8'h81, 8'h00, 1'b1);
    do_txn(1'b0, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0);
    idle(1);
    do_txn(1'b1, 1'b1, 1'b0, 8'h00, 8'h7E, 1'b1);
    do_txn(1'b1, 1'b0, 1'b1, 8'h24, 8'h00, 1'b0);
    idle(1);

    for (int i = 0; i < 12; i++) begin
      nb = 1'($urandom);
      hd = 1'($urandom);
      do_txn(nb, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), hd);
      if (hd) do_txn(nb, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      idle(int'($urandom_range(2, 0)));
    end

    idle(1);
    mid_reset();
    do_txn(1'b0, 1'b1, 1'b1, 8'h00, 8'h5B, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
